// File: rtl/game_seq_pkg.sv
// rtl/game_seq_pkg.sv - state encodings and default constants shared by the game_seq slice
package game_seq_pkg;

    typedef enum logic [2:0] {
        S_ENTER = 3'd0,
        S_CHECK = 3'd1,
        S_P1    = 3'd2,
        S_P2    = 3'd3,
        S_SHOW  = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

    localparam logic [15:0] DEF_KEY            = 16'h3153;
    localparam int unsigned DEF_MAX_FAIL       = 3;
    localparam logic [31:0] DEF_LOCK_CYCLES    = 32'd250000000;
    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd500000000;

endpackage

// File: rtl/game_seq_key_capture.sv
// rtl/game_seq_key_capture.sv - 4-digit keypad capture register with index, done and key match
module game_seq_key_capture
    import game_seq_pkg::*;
#(
    parameter logic [15:0] KEY = DEF_KEY
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       store,
    input  logic       clear,
    input  logic [3:0] digit,
    output logic       done,
    output logic       match
);

    logic [15:0] digits;
    logic [1:0]  idx;

    // digit 0 lands in the top nibble so the register reads like the key literal
    always_ff @(posedge clk) begin
        if (!resetn) begin
            digits <= 16'd0;
            idx    <= 2'd0;
        end else if (clear) begin
            idx <= 2'd0;
        end else if (store) begin
            digits[{2'd3 - idx, 2'b00} +: 4] <= digit;
            idx                              <= idx + 2'd1;
        end
    end

    assign done  = store && (idx == 2'd3);
    assign match = (digits == KEY);

endmodule

// File: rtl/game_seq.sv
// rtl/game_seq.sv - keypad-gated session and turn sequencer; optional idle timeout via IDLE_TIMEOUT_EN
module game_seq
    import game_seq_pkg::*;
#(
    parameter logic [15:0] KEY            = DEF_KEY,
    parameter int unsigned MAX_FAIL       = DEF_MAX_FAIL,
    parameter logic [31:0] LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] acc_data,
    input  logic       acc_bpress,
    input  logic       p1_bpress,
    input  logic       p2_bpress,
    output logic       p1_acc,
    output logic       p2_acc,
    output logic       pass_r,
    output logic       pass_g,
    output logic       sum_valid,
    output logic [2:0] acc_state,
    output logic [2:0] fail_cnt
);

    state_t      state, state_next;
    logic [2:0]  fail_next;
    logic [31:0] lock_cnt, lock_next;
    logic        p1_next, p2_next;
    logic        kc_store, kc_clear, kc_done, kc_match;

    game_seq_key_capture #(.KEY(KEY)) u_key_capture (
        .clk    (CLK),
        .resetn (RST),
        .store  (kc_store),
        .clear  (kc_clear),
        .digit  (acc_data),
        .done   (kc_done),
        .match  (kc_match)
    );

`ifdef IDLE_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        in_session;

    assign in_session = (state == S_P1) || (state == S_P2) || (state == S_SHOW);

    // every accepted press moves the FSM, so a state change covers the press restart too
    always_ff @(posedge CLK) begin
        if (!RST || !in_session || (state_next != state)) begin
            idle_cnt <= 32'd0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_next = state;
        fail_next  = fail_cnt;
        lock_next  = lock_cnt;
        p1_next    = 1'b0;
        p2_next    = 1'b0;
        kc_store   = 1'b0;
        kc_clear   = 1'b0;
        case (state)
            S_ENTER: begin
                if (acc_bpress) begin
                    kc_store = 1'b1;
                    if (kc_done) state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (kc_match) begin
                    fail_next  = 3'd0;
                    state_next = S_P1;
                end else begin
                    fail_next = fail_cnt + 3'd1;
                    if ((32'(fail_cnt) + 32'd1) < MAX_FAIL) begin
                        state_next = S_ENTER;
                    end else begin
                        // counts down to zero inclusive, so the lock lasts LOCK_CYCLES cycles
                        lock_next  = LOCK_CYCLES - 32'd1;
                        state_next = S_LOCK;
                    end
                end
            end
            S_P1: begin
                if (p1_bpress) begin
                    p1_next    = 1'b1;
                    state_next = S_P2;
                end
            end
            S_P2: begin
                if (p2_bpress) begin
                    p2_next    = 1'b1;
                    state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (acc_bpress) begin
                    kc_clear   = 1'b1;
                    state_next = S_ENTER;
                end else if (p1_bpress) begin
                    p1_next    = 1'b1;
                    state_next = S_P2;
                end
            end
            S_LOCK: begin
                if (lock_cnt == 32'd0) begin
                    fail_next  = 3'd0;
                    state_next = S_ENTER;
                end else begin
                    lock_next = lock_cnt - 32'd1;
                end
            end
            default: begin
                kc_clear   = 1'b1;
                state_next = S_ENTER;
            end
        endcase
`ifdef IDLE_TIMEOUT_EN
        if (in_session && (state_next == state) && (idle_cnt == TIMEOUT_CYCLES - 32'd1)) begin
            kc_clear   = 1'b1;
            state_next = S_ENTER;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_ENTER;
            fail_cnt <= 3'd0;
            lock_cnt <= 32'd0;
            p1_acc   <= 1'b0;
            p2_acc   <= 1'b0;
        end else begin
            state    <= state_next;
            fail_cnt <= fail_next;
            lock_cnt <= lock_next;
            p1_acc   <= p1_next;
            p2_acc   <= p2_next;
        end
    end

    assign pass_g    = (state == S_P1) || (state == S_P2) || (state == S_SHOW);
    assign pass_r    = (state == S_LOCK) || ((state == S_ENTER) && (fail_cnt != 3'd0));
    assign sum_valid = (state == S_SHOW);
    assign acc_state = state;

endmodule

// File: tb/tb_game_seq.sv
// tb/tb_game_seq.sv - directed bench for game_seq with a session-level reference model
module tb_game_seq;

    localparam logic [15:0] KEY      = 16'h3153;
    localparam int          MAX_FAIL = 3;
    localparam int          LOCK     = 8;
    localparam int          TO       = 10;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] acc_data = 4'd0;
    logic       acc_bpress = 1'b0;
    logic       p1_bpress = 1'b0;
    logic       p2_bpress = 1'b0;
    logic       p1_acc, p2_acc, pass_r, pass_g, sum_valid;
    logic [2:0] acc_state, fail_cnt;

    game_seq #(
        .KEY            (KEY),
        .MAX_FAIL       (MAX_FAIL),
        .LOCK_CYCLES    (32'(LOCK)),
        .TIMEOUT_CYCLES (32'(TO))
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .acc_data   (acc_data),
        .acc_bpress (acc_bpress),
        .p1_bpress  (p1_bpress),
        .p2_bpress  (p2_bpress),
        .p1_acc     (p1_acc),
        .p2_acc     (p2_acc),
        .pass_r     (pass_r),
        .pass_g     (pass_g),
        .sum_valid  (sum_valid),
        .acc_state  (acc_state),
        .fail_cnt   (fail_cnt)
    );

    always #5 CLK = ~CLK;

    // session model: 0 enter, 1 check, 2 p1 turn, 3 p2 turn, 4 show, 5 locked
    int m_st = 0, m_fail = 0, m_lock = 0, m_idle = 0;
    bit m_p1 = 0, m_p2 = 0;
    int m_q[$];

    function automatic bit key_ok();
        logic [15:0] k;
        k = KEY;
        if (m_q.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (m_q[i] != int'(k[15-4*i -: 4])) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : model
        int prev;
        forever begin
            @(posedge CLK);
            prev = m_st;
            m_p1 = 0;
            m_p2 = 0;
            if (!RST) begin
                m_st = 0; m_fail = 0; m_lock = 0; m_idle = 0;
                m_q.delete();
            end else begin
                case (m_st)
                    0: if (acc_bpress) begin
                           m_q.push_back(int'(acc_data));
                           if (m_q.size() == 4) m_st = 1;
                       end
                    1: begin
                           if (key_ok()) begin
                               m_fail = 0; m_st = 2;
                           end else begin
                               m_fail++;
                               if (m_fail >= MAX_FAIL) begin m_st = 5; m_lock = LOCK; end
                               else m_st = 0;
                           end
                           m_q.delete();
                       end
                    2: if (p1_bpress) begin m_st = 3; m_p1 = 1; end
                    3: if (p2_bpress) begin m_st = 4; m_p2 = 1; end
                    4: if (acc_bpress) m_st = 0;
                       else if (p1_bpress) begin m_st = 3; m_p1 = 1; end
                    5: begin
                           m_lock--;
                           if (m_lock == 0) begin m_fail = 0; m_st = 0; end
                       end
                    default: m_st = 0;
                endcase
`ifdef IDLE_TIMEOUT_EN
                if (m_st == prev && prev >= 2 && prev <= 4) begin
                    m_idle++;
                    if (m_idle == TO) begin m_st = 0; m_idle = 0; end
                end else begin
                    m_idle = 0;
                end
`endif
            end
        end
    end

    int checks = 0, errors = 0;
    bit chk_en = 0;
    bit pin_en = 0;
    int pin_st, pin_fail, pin_g, pin_r, pin_sv, pin_p1, pin_p2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("acc_state", int'(acc_state), m_st);
                chk("fail_cnt", int'(fail_cnt), m_fail);
                chk("pass_g", int'(pass_g), int'(m_st >= 2 && m_st <= 4));
                chk("pass_r", int'(pass_r), int'(m_st == 5 || (m_st == 0 && m_fail != 0)));
                chk("sum_valid", int'(sum_valid), int'(m_st == 4));
                chk("p1_acc", int'(p1_acc), int'(m_p1));
                chk("p2_acc", int'(p2_acc), int'(m_p2));
                if (pin_en) begin
                    chk("pin_model_state", m_st, pin_st);
                    chk("pin_model_fail", m_fail, pin_fail);
                    chk("pin_state", int'(acc_state), pin_st);
                    chk("pin_fail", int'(fail_cnt), pin_fail);
                    chk("pin_pass_g", int'(pass_g), pin_g);
                    chk("pin_pass_r", int'(pass_r), pin_r);
                    chk("pin_sum_valid", int'(sum_valid), pin_sv);
                    chk("pin_p1_acc", int'(p1_acc), pin_p1);
                    chk("pin_p2_acc", int'(p2_acc), pin_p2);
                end
            end
        end
    end

    task automatic step(input bit rst, input bit a, input logic [3:0] d, input bit p1, input bit p2);
        @(posedge CLK);
        #1;
        RST = rst; acc_bpress = a; acc_data = d; p1_bpress = p1; p2_bpress = p2;
        pin_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 4'd0, 0, 0);
    endtask

    task automatic entry(input logic [15:0] code);
        for (int i = 0; i < 4; i++) step(1, 1, code[15-4*i -: 4], 0, 0);
    endtask

    task automatic pin(input int st, input int fl, input int g, input int r,
                       input int sv, input int p1, input int p2);
        pin_st = st; pin_fail = fl; pin_g = g; pin_r = r;
        pin_sv = sv; pin_p1 = p1; pin_p2 = p2;
        pin_en = 1;
    endtask

    initial begin : stimulus
        step(0, 0, 4'd0, 0, 0);
        idle(1);
        chk_en = 1;
        pin(0, 0, 0, 0, 0, 0, 0);

        // correct key: CHECK then P1
        entry(16'h3153);
        idle(1); pin(1, 0, 0, 0, 0, 0, 0);
        idle(1); pin(2, 0, 1, 0, 0, 0, 0);

        // P1 turn ignores p2 and acc
        step(1, 1, 4'd0, 0, 1);
        idle(1); pin(2, 0, 1, 0, 0, 0, 0);
        step(1, 0, 4'd0, 1, 0);
        idle(1); pin(3, 0, 1, 0, 0, 1, 0);
        // P2 turn: only p2 counts even with all three pressed
        step(1, 1, 4'd0, 1, 1);
        idle(1); pin(4, 0, 1, 0, 1, 0, 1);
        idle(1); pin(4, 0, 1, 0, 1, 0, 0);

        // new round from SHOW, then simultaneous acc+p1 logs out without a pulse
        step(1, 0, 4'd0, 1, 0);
        idle(1); pin(3, 0, 1, 0, 0, 1, 0);
        step(1, 0, 4'd0, 0, 1);
        idle(1); pin(4, 0, 1, 0, 1, 0, 1);
        step(1, 1, 4'd0, 1, 0);
        idle(1); pin(0, 0, 0, 0, 0, 0, 0);

        // three bad entries lead to lockout of exactly LOCK cycles
        entry(16'h3154);
        idle(1); pin(1, 0, 0, 0, 0, 0, 0);
        idle(1); pin(0, 1, 0, 1, 0, 0, 0);
        entry(16'h0000);
        idle(2); pin(0, 2, 0, 1, 0, 0, 0);
        entry(16'h1111);
        idle(1); pin(1, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < LOCK; i++) begin
            step(1, 1, 4'd3, 1, 1);
            pin(5, 3, 0, 1, 0, 0, 0);
        end
        idle(1); pin(0, 0, 0, 0, 0, 0, 0);

        // a good entry after one failure clears the count
        entry(16'h0000);
        idle(2); pin(0, 1, 0, 1, 0, 0, 0);
        entry(16'h3153);
        idle(2); pin(2, 0, 1, 0, 0, 0, 0);
        step(1, 0, 4'd0, 1, 0);
        step(1, 0, 4'd0, 0, 1);
        step(1, 1, 4'd0, 0, 0);
        idle(1); pin(0, 0, 0, 0, 0, 0, 0);

        // reset mid-entry restarts digit capture
        step(1, 1, 4'd3, 0, 0);
        step(1, 1, 4'd1, 0, 0);
        step(0, 0, 4'd0, 0, 0);
        idle(1); pin(0, 0, 0, 0, 0, 0, 0);
        entry(16'h3153);
        idle(2); pin(2, 0, 1, 0, 0, 0, 0);

        // reset mid-lockout clears fail count
        step(1, 0, 4'd0, 1, 0);
        step(1, 0, 4'd0, 0, 1);
        step(1, 1, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            entry(16'h9999);
            idle(1);
        end
        idle(3); pin(5, 3, 0, 1, 0, 0, 0);
        step(0, 0, 4'd0, 0, 0);
        idle(1); pin(0, 0, 0, 0, 0, 0, 0);
        entry(16'h3153);
        idle(2); pin(2, 0, 1, 0, 0, 0, 0);

`ifdef IDLE_TIMEOUT_EN
        // idle in P2 for TO cycles drops back to ENTER
        step(1, 0, 4'd0, 1, 0);
        idle(1); pin(3, 0, 1, 0, 0, 1, 0);
        idle(TO - 1); pin(3, 0, 1, 0, 0, 0, 0);
        idle(1); pin(0, 0, 0, 0, 0, 0, 0);
        // a press in the last idle cycle of SHOW restarts the count
        entry(16'h3153);
        idle(2); pin(2, 0, 1, 0, 0, 0, 0);
        step(1, 0, 4'd0, 1, 0);
        step(1, 0, 4'd0, 0, 1);
        idle(1); pin(4, 0, 1, 0, 1, 0, 1);
        idle(TO - 2);
        step(1, 0, 4'd0, 1, 0);
        idle(1); pin(3, 0, 1, 0, 0, 1, 0);
        idle(TO - 1); pin(3, 0, 1, 0, 0, 0, 0);
        idle(1); pin(0, 0, 0, 0, 0, 0, 0);
`else
        // without the timeout the session persists
        idle(3 * TO); pin(2, 0, 1, 0, 0, 0, 0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
